// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline: merges load-use, I/D-memory wait
// and branch mispredict into PC and pipeline-register load/flush enables.
module pipeline_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_stall,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             br_mispredict,
    input  logic [XLEN-1:0]  br_target,
    output logic             pc_load,
    output logic             pc_sel,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             redir_pend,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, REDIR} state_t;

    state_t state;
    logic   mstall;
    logic   fstall;
    logic   take_br;
    logic   enter_redir;
    logic   leave_redir;
    logic   stall_evt;

    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign mstall = dmem_req & ~dmem_resp;
    assign fstall = imem_read & ~imem_resp;

    always_comb begin
        pc_load     = 1'b0;
        pc_sel      = 1'b0;
        if_id_load  = 1'b0;
        id_ex_load  = 1'b0;
        ex_mem_load = 1'b0;
        mem_wb_load = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        take_br     = 1'b0;
        enter_redir = 1'b0;
        leave_redir = 1'b0;
        stall_evt   = 1'b0;
        if (rst) begin
            if (state == RUN) begin
                if (mstall) begin
                    stall_evt = 1'b1;
                end else if (br_mispredict) begin
                    take_br     = 1'b1;
                    if_id_load  = 1'b1;
                    id_ex_load  = 1'b1;
                    ex_mem_load = 1'b1;
                    mem_wb_load = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    // A fetch still in flight must land before the PC can be redirected.
                    pc_load     = ~fstall;
                    enter_redir = fstall;
                end else if (load_use_stall) begin
                    stall_evt   = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_load = 1'b1;
                    mem_wb_load = 1'b1;
                end else if (fstall) begin
                    if_id_flush = 1'b1;
                    id_ex_load  = 1'b1;
                    ex_mem_load = 1'b1;
                    mem_wb_load = 1'b1;
                end else begin
                    pc_load     = 1'b1;
                    if_id_load  = 1'b1;
                    id_ex_load  = 1'b1;
                    ex_mem_load = 1'b1;
                    mem_wb_load = 1'b1;
                end
            end else begin
                // Wrong-path fetch in flight: ID only ever sees bubbles.
                if_id_flush = 1'b1;
                id_ex_load  = ~mstall;
                ex_mem_load = ~mstall;
                mem_wb_load = ~mstall;
                stall_evt   = mstall;
                pc_load     = imem_resp;
                pc_sel      = imem_resp;
                leave_redir = imem_resp;
            end
        end
    end

    assign redir_pend = (state == REDIR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            redirect_pc <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if (take_br) begin
                redirect_pc <= br_target;
                flush_cnt   <= wrap_inc(flush_cnt);
            end
            if (stall_evt) begin
                stall_cnt <= wrap_inc(stall_cnt);
            end
            if (enter_redir) begin
                state <= REDIR;
            end else if (leave_redir) begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table through a scoreboard queue, plus reset sequences.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_use_stall, imem_read, imem_resp, dmem_req, dmem_resp, br_mispredict;
    logic [31:0] br_target;
    logic        pc_load, pc_sel, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_flush, id_ex_flush, redir_pend;
    logic [31:0] redirect_pc, stall_cnt, flush_cnt;

    pipeline_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .load_use_stall(load_use_stall), .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .br_mispredict(br_mispredict), .br_target(br_target),
        .pc_load(pc_load), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
        .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .redir_pend(redir_pend), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // ctl bit order: pc_load pc_sel if_id_load id_ex_load ex_mem_load mem_wb_load
    //                if_id_flush id_ex_flush redir_pend
    localparam logic [8:0] C_IDLE = 9'b1_0_1_1_1_1_0_0_0;
    localparam logic [8:0] C_LU   = 9'b0_0_0_0_1_1_0_1_0;
    localparam logic [8:0] C_MS   = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] C_BR   = 9'b1_0_1_1_1_1_1_1_0;
    localparam logic [8:0] C_BRF  = 9'b0_0_1_1_1_1_1_1_0;
    localparam logic [8:0] C_RD   = 9'b0_0_0_1_1_1_1_0_1;
    localparam logic [8:0] C_RDR  = 9'b1_1_0_1_1_1_1_0_1;
    localparam logic [8:0] C_RDRM = 9'b1_1_0_0_0_0_1_0_1;
    localparam logic [8:0] C_FS   = 9'b0_0_0_1_1_1_1_0_0;

    typedef struct {
        int          id;
        logic        lu, ir, irsp, dr, drsp, bm;
        logic [31:0] bt;
        logic [8:0]  ctl;
        logic [31:0] rpc, sc, fc;
    } vec_t;

    vec_t vt[26];
    vec_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic lu, ir, irsp, dr, drsp, bm, input logic [31:0] bt,
                                input logic [8:0] ctl, input logic [31:0] rpc, sc, fc);
        vec_t v;
        v.id = 0; v.lu = lu; v.ir = ir; v.irsp = irsp; v.dr = dr; v.drsp = drsp; v.bm = bm;
        v.bt = bt; v.ctl = ctl; v.rpc = rpc; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [8:0] ctl_now();
        return {pc_load, pc_sel, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                if_id_flush, id_ex_flush, redir_pend};
    endfunction

    task automatic drive(input logic lu, ir, irsp, dr, drsp, bm, input logic [31:0] bt);
        load_use_stall = lu; imem_read = ir; imem_resp = irsp;
        dmem_req = dr; dmem_resp = drsp; br_mispredict = bm; br_target = bt;
    endtask

    // Scoreboard consumer: compares outputs mid-cycle against the record pushed at this negedge.
    always @(negedge clk) begin
        #2;
        if (sbq.size() > 0) begin
            vec_t e;
            e = sbq.pop_front();
            chk($sformatf("vec%0d.ctl", e.id), {23'b0, ctl_now()}, {23'b0, e.ctl});
            chk($sformatf("vec%0d.redirect_pc", e.id), redirect_pc, e.rpc);
            chk($sformatf("vec%0d.stall_cnt", e.id), stall_cnt, e.sc);
            chk($sformatf("vec%0d.flush_cnt", e.id), flush_cnt, e.fc);
        end
    end

    initial begin
        //            lu ir rs dr ds bm bt      ctl     rpc    sc fc
        vt[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  C_IDLE, 32'h0,  0, 0);
        vt[1]  = mk(1, 0, 0, 0, 0, 0, 32'h0,  C_LU,   32'h0,  0, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  C_IDLE, 32'h0,  1, 0);
        vt[3]  = mk(0, 0, 0, 1, 0, 0, 32'h0,  C_MS,   32'h0,  1, 0);
        vt[4]  = mk(0, 0, 0, 1, 0, 0, 32'h0,  C_MS,   32'h0,  2, 0);
        vt[5]  = mk(0, 0, 0, 1, 0, 0, 32'h0,  C_MS,   32'h0,  3, 0);
        vt[6]  = mk(0, 0, 0, 1, 0, 0, 32'h0,  C_MS,   32'h0,  4, 0);
        vt[7]  = mk(0, 0, 0, 1, 1, 0, 32'h0,  C_IDLE, 32'h0,  5, 0);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  C_IDLE, 32'h0,  5, 0);
        vt[9]  = mk(0, 0, 0, 0, 0, 1, 32'h60, C_BR,   32'h0,  5, 0);
        vt[10] = mk(0, 0, 0, 0, 0, 0, 32'h0,  C_IDLE, 32'h60, 5, 1);
        vt[11] = mk(0, 1, 0, 0, 0, 1, 32'h80, C_BRF,  32'h60, 5, 1);
        vt[12] = mk(0, 1, 0, 0, 0, 0, 32'h0,  C_RD,   32'h80, 5, 2);
        vt[13] = mk(1, 1, 0, 0, 0, 1, 32'h44, C_RD,   32'h80, 5, 2);
        vt[14] = mk(0, 1, 1, 0, 0, 0, 32'h0,  C_RDR,  32'h80, 5, 2);
        vt[15] = mk(0, 0, 0, 0, 0, 0, 32'h0,  C_IDLE, 32'h80, 5, 2);
        vt[16] = mk(1, 0, 0, 0, 0, 1, 32'h10, C_BR,   32'h80, 5, 2);
        vt[17] = mk(0, 0, 0, 0, 0, 0, 32'h0,  C_IDLE, 32'h10, 5, 3);
        vt[18] = mk(0, 1, 0, 0, 0, 0, 32'h0,  C_FS,   32'h10, 5, 3);
        vt[19] = mk(0, 0, 0, 1, 0, 1, 32'h20, C_MS,   32'h10, 5, 3);
        vt[20] = mk(0, 0, 0, 0, 0, 0, 32'h0,  C_IDLE, 32'h10, 6, 3);
        vt[21] = mk(0, 1, 0, 0, 0, 1, 32'h30, C_BRF,  32'h10, 6, 3);
        vt[22] = mk(0, 1, 1, 1, 0, 0, 32'h0,  C_RDRM, 32'h30, 6, 4);
        vt[23] = mk(0, 0, 0, 0, 0, 0, 32'h0,  C_IDLE, 32'h30, 7, 4);
        vt[24] = mk(1, 1, 1, 0, 0, 0, 32'h0,  C_LU,   32'h30, 7, 4);
        vt[25] = mk(0, 0, 0, 0, 0, 0, 32'h0,  C_IDLE, 32'h30, 8, 4);
        for (int i = 0; i < 26; i++) vt[i].id = i;

        // Reset held with random inputs: every enable low, counters clear.
        rst = 1'b0;
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), $urandom);
        #2;
        chk("reset.ctl", {23'b0, ctl_now()}, 32'h0);
        chk("reset.stall_cnt", stall_cnt, 32'h0);
        chk("reset.flush_cnt", flush_cnt, 32'h0);
        chk("reset.redirect_pc", redirect_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h0);

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].lu, vt[i].ir, vt[i].irsp, vt[i].dr, vt[i].drsp, vt[i].bm, vt[i].bt);
            sbq.push_back(vt[i]);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            n_total++;
            $display("FAIL sb_drain: %0d entries left, required 0", sbq.size());
        end

        // Reset arriving mid-REDIR discards the pending redirect.
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 1, 32'h50);
        #2;
        chk("redir_entry.ctl", {23'b0, ctl_now()}, {23'b0, C_BRF});
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0, 32'h0);
        #2;
        chk("in_redir.ctl", {23'b0, ctl_now()}, {23'b0, C_RD});
        chk("in_redir.redirect_pc", redirect_pc, 32'h50);
        chk("in_redir.flush_cnt", flush_cnt, 32'd5);
        rst = 1'b0;
        #1;
        chk("mid_rst.ctl", {23'b0, ctl_now()}, 32'h0);
        chk("mid_rst.redirect_pc", redirect_pc, 32'h0);
        chk("mid_rst.stall_cnt", stall_cnt, 32'h0);
        chk("mid_rst.flush_cnt", flush_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("post_rst.ctl", {23'b0, ctl_now()}, {23'b0, C_IDLE});
        @(negedge clk);
        drive(0, 1, 1, 0, 0, 0, 32'h0);
        #2;
        chk("post_rst_resp.ctl", {23'b0, ctl_now()}, {23'b0, C_IDLE});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
